// File: rtl/pulse_measure_sequencer.sv
// Sequences frequency_counter measurements: gates the input, drops the first partial
// pulse, averages 2**LOG2_AVG high/low/period triples and streams the averages out.
module pulse_measure_sequencer #(
   parameter int COUNTER_BITS = 8,
   parameter int LOG2_AVG     = 2,
   parameter int TIMEOUT_BITS = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    abort,
   input  logic                    pulse,
   input  logic [COUNTER_BITS-1:0] time_high,
   input  logic [COUNTER_BITS-1:0] time_low,
   input  logic [COUNTER_BITS-1:0] period,
   output logic                    meas_en,
   output logic                    busy,
   output logic                    timeout,
   output logic [COUNTER_BITS-1:0] data_out,
   output logic [1:0]              data_sel,
   output logic                    data_valid,
   input  logic                    data_ready
);

   localparam int ACC_BITS = COUNTER_BITS + LOG2_AVG;
   localparam int CNT_BITS = LOG2_AVG + 1;
   localparam logic [CNT_BITS-1:0]     LAST_SAMPLE = CNT_BITS'((1 << LOG2_AVG) - 1);
   localparam logic [TIMEOUT_BITS-1:0] WD_MAX      = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_DISCARD, S_COLLECT, S_DIVIDE, S_SEND_HI, S_SEND_LO, S_SEND_PER
   } state_t;

   state_t state_reg, state_next;

   logic                    meas_en_reg, meas_en_next;
   logic                    busy_reg, busy_next;
   logic                    timeout_reg, timeout_next;
   logic                    data_valid_reg, data_valid_next;
   logic [COUNTER_BITS-1:0] data_out_reg, data_out_next;
   logic [1:0]              data_sel_reg, data_sel_next;

   logic [TIMEOUT_BITS-1:0] wd_reg;
   logic [CNT_BITS-1:0]     cnt_reg;

   // Lanes are indexed by the word id used on data_sel: 2=high, 1=low, 0=period.
   logic [2:0][COUNTER_BITS-1:0] sample_in;
   logic [2:0][COUNTER_BITS-1:0] avg;

   logic measuring;
   logic wd_expired;
   logic start_accept;
   logic sample_take;

   assign sample_in[0] = period;
   assign sample_in[1] = time_low;
   assign sample_in[2] = time_high;

   assign measuring    = (state_reg == S_DISCARD) || (state_reg == S_COLLECT);
   assign wd_expired   = measuring && (wd_reg == WD_MAX);
   assign start_accept = (state_reg == S_IDLE) && start && !abort;
   assign sample_take  = (state_reg == S_COLLECT) && pulse && !wd_expired && !abort;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_lane
         logic [ACC_BITS-1:0] acc_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               acc_reg <= '0;
            end else if (start_accept) begin
               acc_reg <= '0;
            end else if (sample_take) begin
               acc_reg <= acc_reg + ACC_BITS'(sample_in[gi]);
            end
         end

         // Dropping the low LOG2_AVG bits is the floor of the mean.
         assign avg[gi] = acc_reg[ACC_BITS-1 -: COUNTER_BITS];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_reg  <= '0;
         cnt_reg <= '0;
      end else if (start_accept) begin
         wd_reg  <= '0;
         cnt_reg <= '0;
      end else begin
         if (measuring) begin
            wd_reg <= pulse ? '0 : wd_reg + TIMEOUT_BITS'(1);
         end
         if (sample_take) begin
            cnt_reg <= cnt_reg + CNT_BITS'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= S_IDLE;
         meas_en_reg    <= 1'b0;
         busy_reg       <= 1'b0;
         timeout_reg    <= 1'b0;
         data_valid_reg <= 1'b0;
         data_out_reg   <= '0;
         data_sel_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         meas_en_reg    <= meas_en_next;
         busy_reg       <= busy_next;
         timeout_reg    <= timeout_next;
         data_valid_reg <= data_valid_next;
         data_out_reg   <= data_out_next;
         data_sel_reg   <= data_sel_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (abort) begin
         state_next = S_IDLE;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) state_next = S_DISCARD;
            end
            S_DISCARD: begin
               if (wd_expired)  state_next = S_IDLE;
               else if (pulse)  state_next = S_COLLECT;
            end
            S_COLLECT: begin
               if (wd_expired)                            state_next = S_IDLE;
               else if (pulse && (cnt_reg == LAST_SAMPLE)) state_next = S_DIVIDE;
            end
            S_DIVIDE:   state_next = S_SEND_HI;
            S_SEND_HI:  if (data_ready) state_next = S_SEND_LO;
            S_SEND_LO:  if (data_ready) state_next = S_SEND_PER;
            S_SEND_PER: if (data_ready) state_next = S_IDLE;
            default:    state_next = S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the upcoming state so they leave the same flops as the state.
   always_comb begin
      meas_en_next    = (state_next == S_DISCARD) || (state_next == S_COLLECT);
      busy_next       = (state_next != S_IDLE);
      data_valid_next = 1'b0;
      data_sel_next   = 2'd0;
      data_out_next   = '0;
      case (state_next)
         S_SEND_HI: begin
            data_valid_next = 1'b1;
            data_sel_next   = 2'd2;
         end
         S_SEND_LO: begin
            data_valid_next = 1'b1;
            data_sel_next   = 2'd1;
         end
         S_SEND_PER: begin
            data_valid_next = 1'b1;
            data_sel_next   = 2'd0;
         end
         default: ;
      endcase
      if (data_valid_next) data_out_next = avg[data_sel_next];

      timeout_next = timeout_reg;
      if (start_accept)              timeout_next = 1'b0;
      else if (wd_expired && !abort) timeout_next = 1'b1;
   end

   assign meas_en    = meas_en_reg;
   assign busy       = busy_reg;
   assign timeout    = timeout_reg;
   assign data_valid = data_valid_reg;
   assign data_out   = data_out_reg;
   assign data_sel   = data_sel_reg;

endmodule

// File: tb/tb_pulse_measure_sequencer.sv
// Directed bench for pulse_measure_sequencer: a sample-queue model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_pulse_measure_sequencer;

   localparam int LA     = 2;
   localparam int NSAMP  = 1 << LA;
   localparam int WD_MAX = (1 << 10) - 1;

   localparam int PH_IDLE    = 0;
   localparam int PH_DISCARD = 1;
   localparam int PH_COLLECT = 2;
   localparam int PH_DIVIDE  = 3;
   localparam int PH_SEND    = 4;

   logic       clk = 1'b0;
   logic       rst_n, start, abort, pulse, data_ready;
   logic [7:0] time_high, time_low, period, data_out;
   logic       meas_en, busy, timeout, data_valid;
   logic [1:0] data_sel;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int c_last = 0;

   int ph[5], pl[5], pp[5];

   // model state
   int m_phase = PH_IDLE;
   int m_wd = 0;
   int m_k = 0;
   bit m_timeout = 1'b0;
   int q_hi[$], q_lo[$], q_per[$];
   int words[3];

   int obs_data[$], obs_sel[$], obs_cyc[$];

   pulse_measure_sequencer #(.COUNTER_BITS(8), .LOG2_AVG(LA), .TIMEOUT_BITS(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pulse(pulse),
      .time_high(time_high), .time_low(time_low), .period(period),
      .meas_en(meas_en), .busy(busy), .timeout(timeout),
      .data_out(data_out), .data_sel(data_sel), .data_valid(data_valid),
      .data_ready(data_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Predicts what the DUT holds after the coming rising edge from the inputs now applied.
   task automatic model_step();
      int s_hi, s_lo, s_per;
      if (!rst_n) begin
         m_phase = PH_IDLE; m_timeout = 1'b0; m_wd = 0; m_k = 0;
         q_hi.delete(); q_lo.delete(); q_per.delete();
         return;
      end
      if (abort) begin
         m_phase = PH_IDLE;
         return;
      end
      case (m_phase)
         PH_IDLE: if (start) begin
            m_phase = PH_DISCARD; m_wd = 0; m_timeout = 1'b0;
            q_hi.delete(); q_lo.delete(); q_per.delete();
         end
         PH_DISCARD, PH_COLLECT: begin
            if (m_wd == WD_MAX) begin
               m_timeout = 1'b1; m_phase = PH_IDLE;
            end else if (pulse) begin
               m_wd = 0;
               if (m_phase == PH_DISCARD) m_phase = PH_COLLECT;
               else begin
                  q_hi.push_back(int'(time_high));
                  q_lo.push_back(int'(time_low));
                  q_per.push_back(int'(period));
                  if (q_hi.size() == NSAMP) m_phase = PH_DIVIDE;
               end
            end else m_wd++;
         end
         PH_DIVIDE: begin
            s_hi = 0; s_lo = 0; s_per = 0;
            foreach (q_hi[i]) begin
               s_hi += q_hi[i]; s_lo += q_lo[i]; s_per += q_per[i];
            end
            words[0] = s_hi / NSAMP; words[1] = s_lo / NSAMP; words[2] = s_per / NSAMP;
            m_k = 0; m_phase = PH_SEND;
         end
         PH_SEND: if (data_ready) begin
            m_k++;
            if (m_k == 3) m_phase = PH_IDLE;
         end
         default: m_phase = PH_IDLE;
      endcase
   endtask

   initial forever begin
      @(negedge clk);
      #2;
      if (rst_n && data_valid && data_ready) begin
         obs_data.push_back(int'(data_out));
         obs_sel.push_back(int'(data_sel));
         obs_cyc.push_back(cyc);
      end
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         check("cyc_busy", int'(busy), int'(m_phase != PH_IDLE));
         check("cyc_meas_en", int'(meas_en), int'(m_phase == PH_DISCARD || m_phase == PH_COLLECT));
         check("cyc_timeout", int'(timeout), int'(m_timeout));
         check("cyc_data_valid", int'(data_valid), int'(m_phase == PH_SEND));
         if (m_phase == PH_SEND) begin
            check("cyc_data_out", int'(data_out), words[m_k]);
            check("cyc_data_sel", int'(data_sel), 2 - m_k);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1, "bench watchdog");
   end

   task automatic do_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic do_pulse(input int hi, input int lo, input int per);
      time_high = 8'(hi); time_low = 8'(lo); period = 8'(per);
      pulse = 1'b1; tick(); pulse = 1'b0;
   endtask

   task automatic feed(input int gap);
      for (int i = 0; i < 5; i++) begin
         if (i == 4) c_last = cyc;
         do_pulse(ph[i], pl[i], pp[i]);
         if (i < 4) repeat (gap) tick();
      end
   endtask

   task automatic load_spec_samples();
      ph = '{10, 10, 11, 12, 13};
      pl = '{20, 20, 21, 22, 23};
      pp = '{30, 30, 31, 32, 33};
   endtask

   task automatic clear_obs();
      obs_data.delete(); obs_sel.delete(); obs_cyc.delete();
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!data_valid && n < 20) begin tick(); n++; end
      if (!data_valid) check(name, int'(data_valid), 1);
   endtask

   task automatic wait_obs(input string name, input int budget);
      int n = 0;
      while (obs_data.size() < 3 && n < budget) begin tick(); n++; end
      check(name, obs_data.size(), 3);
   endtask

   task automatic check_words(input string name, input int a, input int b, input int c);
      if (obs_data.size() >= 3) begin
         check({name, "_w0"}, obs_data[0], a);
         check({name, "_w1"}, obs_data[1], b);
         check({name, "_w2"}, obs_data[2], c);
         check({name, "_sel0"}, obs_sel[0], 2);
         check({name, "_sel1"}, obs_sel[1], 1);
         check({name, "_sel2"}, obs_sel[2], 0);
      end
   endtask

   initial begin
      int n;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; pulse = 1'b0; data_ready = 1'b0;
      time_high = '0; time_low = '0; period = '0;
      repeat (2) tick();
      check("rst_busy", int'(busy), 0);
      check("rst_valid", int'(data_valid), 0);
      check("rst_meas_en", int'(meas_en), 0);
      check("rst_timeout", int'(timeout), 0);
      check("rst_data_out", int'(data_out), 0);
      rst_n = 1'b1;
      tick();

      // Averaging with READY tied high; first pulse discarded.
      $display("test 2: average of 4 samples, ready high");
      clear_obs(); load_spec_samples(); data_ready = 1'b1;
      do_start();
      check("t2_meas_en_rise", int'(meas_en), 1);
      feed(2);
      check("t2_divide_meas_en", int'(meas_en), 0);
      check("t2_divide_busy", int'(busy), 1);
      check("t2_divide_valid", int'(data_valid), 0);
      tick();
      check("t2_first_valid", int'(data_valid), 1);
      check("t2_first_word", int'(data_out), 11);
      wait_obs("t2_words_seen", 10);
      check_words("t2", 11, 21, 31);
      if (obs_cyc.size() >= 3) begin
         check("t2_latency", obs_cyc[0] - c_last, 2);
         check("t2_back_to_back", obs_cyc[2] - obs_cyc[0], 2);
      end
      for (int i = 0; i < obs_data.size(); i++)
         $display("  word %0d sel=%0d data=%0d", i, obs_sel[i], obs_data[i]);

      // Back-pressure: each word held for 4 cycles before it is accepted.
      $display("test 3: ready low 4 cycles per word");
      clear_obs(); data_ready = 1'b0;
      do_start();
      feed(1);
      for (int w = 0; w < 3; w++) begin
         wait_valid("t3_valid_wait");
         repeat (4) begin
            check("t3_held_sel", int'(data_sel), 2 - w);
            check("t3_held_data", int'(data_out), (w == 0) ? 11 : (w == 1) ? 21 : 31);
            tick();
         end
         data_ready = 1'b1; tick(); data_ready = 1'b0;
      end
      wait_obs("t3_words_seen", 5);
      check_words("t3", 11, 21, 31);

      // Watchdog: no pulse after start.
      $display("test 4: watchdog expiry");
      clear_obs(); data_ready = 1'b1;
      do_start();
      n = 1;
      while (!timeout && n < 1100) begin tick(); n++; end
      check("t4_timeout_cycle", n, 1025);
      check("t4_timeout", int'(timeout), 1);
      check("t4_busy", int'(busy), 0);
      check("t4_no_words", obs_data.size(), 0);
      repeat (3) tick();
      check("t4_sticky", int'(timeout), 1);
      do_start();
      check("t4_cleared", int'(timeout), 0);
      check("t4_restart_busy", int'(busy), 1);
      abort = 1'b1; tick(); abort = 1'b0;
      check("t4_abort_busy", int'(busy), 0);

      // Abort mid-collection, then a full-scale measurement.
      $display("test 5: abort then full-scale samples");
      clear_obs();
      do_start();
      do_pulse(50, 60, 70);
      do_pulse(90, 80, 70);
      do_pulse(91, 81, 71);
      abort = 1'b1; tick(); abort = 1'b0;
      check("t5_abort_busy", int'(busy), 0);
      check("t5_abort_meas_en", int'(meas_en), 0);
      check("t5_abort_timeout", int'(timeout), 0);
      ph = '{200, 200, 200, 200, 200};
      pl = '{100, 100, 100, 100, 100};
      pp = '{255, 255, 255, 255, 255};
      do_start();
      feed(1);
      wait_obs("t5_words_seen", 10);
      check_words("t5", 200, 100, 255);

      // START while busy and PULSE while idle are both ignored.
      $display("test 6: stray start and pulse");
      clear_obs();
      do_pulse(99, 99, 99);
      do_pulse(99, 99, 99);
      check("t6_idle_pulse_busy", int'(busy), 0);
      do_start();
      do_start();
      do_pulse(1, 1, 1);
      do_pulse(4, 8, 12);
      do_pulse(8, 16, 24);
      do_start();
      do_pulse(12, 24, 36);
      start = 1'b1;
      do_pulse(16, 32, 48);
      start = 1'b0;
      wait_obs("t6_words_seen", 10);
      check_words("t6", 10, 20, 30);

      // Asynchronous reset while the low word is on the port.
      $display("test 1: reset during SEND_LO");
      clear_obs(); load_spec_samples(); data_ready = 1'b0;
      do_start();
      feed(1);
      wait_valid("t1_valid_wait");
      data_ready = 1'b1; tick(); data_ready = 1'b0;
      check("t1_in_send_lo", int'(data_sel), 1);
      check("t1_valid_before", int'(data_valid), 1);
      #1 rst_n = 1'b0;
      #1;
      check("t1_rst_valid", int'(data_valid), 0);
      check("t1_rst_busy", int'(busy), 0);
      check("t1_rst_meas_en", int'(meas_en), 0);
      check("t1_rst_timeout", int'(timeout), 0);
      check("t1_rst_data_out", int'(data_out), 0);
      check("t1_rst_data_sel", int'(data_sel), 0);
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
      check("t1_idle_after", int'(busy), 0);
      check("t1_no_more_words", obs_data.size(), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
